// File: rtl/exposure_timer.sv
// Exposure-time counter: counts prescaled ticks up to a latched length
// and pulses o_ovf for one cycle at the end. Supports abort, retrigger, auto-reload.
module exposure_timer #(
    parameter int WIDTH      = 5,
    parameter int PRESCALE_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_auto_reload,
    input  logic [WIDTH-1:0]      i_ex_time,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_ovf,
    output logic                  o_busy,
    output logic [WIDTH-1:0]      o_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_n;
    logic [PRESCALE_W-1:0] r_p;
    logic [WIDTH-1:0]      r_cnt;
    logic [PRESCALE_W-1:0] r_ps;
    logic                  r_ovf;
    logic                  r_start_d;

    state_t                w_state_nxt;
    logic [WIDTH-1:0]      w_n_nxt;
    logic [PRESCALE_W-1:0] w_p_nxt;
    logic [WIDTH-1:0]      w_cnt_nxt;
    logic [PRESCALE_W-1:0] w_ps_nxt;
    logic                  w_ovf_nxt;
    logic                  w_start_edge;
    logic                  w_tick;

    assign w_start_edge = i_start & ~r_start_d;
    assign w_tick       = (r_ps == r_p);

    // State and datapath registers; edge detector resets high so a held Start is ignored
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_ps      <= '0;
            r_ovf     <= 1'b0;
            r_start_d <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_n       <= w_n_nxt;
            r_p       <= w_p_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ps      <= w_ps_nxt;
            r_ovf     <= w_ovf_nxt;
            r_start_d <= i_start;
        end
    end

    // Next-state logic: abort beats start edge, start edge beats tick
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_p_nxt     = r_p;
        w_cnt_nxt   = r_cnt;
        w_ps_nxt    = r_ps;
        w_ovf_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_RUN;
                    w_n_nxt     = i_ex_time;
                    w_p_nxt     = i_prescale;
                    w_cnt_nxt   = '0;
                    w_ps_nxt    = '0;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_ps_nxt    = '0;
                end else if (w_start_edge) begin
                    w_n_nxt   = i_ex_time;
                    w_p_nxt   = i_prescale;
                    w_cnt_nxt = '0;
                    w_ps_nxt  = '0;
                end else if (w_tick) begin
                    w_ps_nxt = '0;
                    if (r_cnt == r_n) begin
                        w_ovf_nxt = 1'b1;
                        w_cnt_nxt = '0;
                        if (i_auto_reload) begin
                            w_n_nxt = i_ex_time;
                            w_p_nxt = i_prescale;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_ps_nxt = r_ps + 1'b1;
                end
            end
        endcase
    end

    // Outputs taken straight from registers
    always_comb begin
        o_busy  = (r_state == S_RUN);
        o_count = r_cnt;
        o_ovf   = r_ovf;
    end

endmodule

// File: tb/tb_exposure_timer.sv
// Testbench for exposure_timer: expected Ovf cycles are queued when a start
// is driven and matched against Ovf pulses seen by a monitor.
module tb_exposure_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       autor;
    logic [4:0] ex_time;
    logic [3:0] prescale;
    logic       ovf;
    logic       busy;
    logic [4:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];

    exposure_timer #(.WIDTH(5), .PRESCALE_W(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_auto_reload (autor),
        .i_ex_time     (ex_time),
        .i_prescale    (prescale),
        .o_ovf         (ovf),
        .o_busy        (busy),
        .o_count       (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: match Ovf pulses against queued cycles
    always @(negedge clk) begin
        if (ovf) begin
            if (exp_q.size() > 0) chk("ovf_cycle", cyc, exp_q.pop_front());
            else chk("ovf_spurious", 1, 0);
        end else if (exp_q.size() > 0 && cyc > exp_q[0]) begin
            chk("ovf_missing", cyc, exp_q.pop_front());
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; leaves start low one negedge later
    task automatic start_pulse(input int n, input int p, input bit push);
        ex_time  = 5'(n);
        prescale = 4'(p);
        start    = 1'b1;
        if (push) exp_q.push_back(cyc + 1 + (n + 1) * (p + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_check(input int n, input int p);
        int lat;
        lat = (n + 1) * (p + 1);
        start_pulse(n, p, 1'b1);
        for (int k = 0; k < lat; k++) begin
            chk("count_run", count, k / (p + 1));
            chk("busy_run", busy, 1);
            @(negedge clk);
        end
        chk("ovf_end", ovf, 1);
        chk("busy_end", busy, 0);
        chk("count_end", count, 0);
        @(negedge clk);
        chk("ovf_once", ovf, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c;
        rst = 1'b1; start = 1'b1; abort = 1'b0; autor = 1'b0;
        ex_time = '0; prescale = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start_busy", busy, 0);
        start = 1'b0;
        @(negedge clk);

        run_check(4, 0);
        run_check(4, 2);
        run_check(0, 0);
        run_check(1, 15);
        run_check(31, 0);

        // auto-reload, N=2 P=1: period 6
        autor = 1'b1;
        c = cyc;
        start_pulse(2, 1, 1'b1);
        exp_q.push_back(c + 13);
        exp_q.push_back(c + 19);
        wait_until(c + 7);
        chk("ar_busy7", busy, 1);
        chk("ar_count7", count, 0);
        wait_until(c + 8);
        chk("ar_busy8", busy, 1);
        wait_until(c + 14);
        autor = 1'b0;
        wait_until(c + 19);
        chk("ar_busy_end", busy, 0);
        repeat (4) @(negedge clk);

        // auto-reload with N=P=0: Ovf every cycle
        autor = 1'b1;
        c = cyc;
        start_pulse(0, 0, 1'b1);
        exp_q.push_back(c + 3);
        exp_q.push_back(c + 4);
        exp_q.push_back(c + 5);
        wait_until(c + 4);
        autor = 1'b0;
        wait_until(c + 5);
        chk("ar0_busy_end", busy, 0);
        repeat (3) @(negedge clk);

        // abort mid-run
        c = cyc;
        start_pulse(7, 0, 1'b0);
        wait_until(c + 3);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 0);
        abort = 1'b0;
        repeat (10) @(negedge clk);

        // abort together with terminal tick
        c = cyc;
        start_pulse(2, 0, 1'b0);
        wait_until(c + 3);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_term_busy", busy, 0);
        chk("abort_term_ovf", ovf, 0);
        abort = 1'b0;
        repeat (5) @(negedge clk);

        // retrigger at cycle 3, Ex_time change mid-run ignored
        c = cyc;
        start_pulse(5, 0, 1'b0);
        wait_until(c + 3);
        start_pulse(5, 0, 1'b1);
        chk("retrig_count", count, 0);
        chk("retrig_busy", busy, 1);
        ex_time = 5'd1;
        wait_until(c + 6);
        chk("retrig_count2", count, 2);
        wait_until(c + 10);
        chk("retrig_busy_end", busy, 0);
        repeat (3) @(negedge clk);

        // reset mid-run with Start held high
        c = cyc;
        ex_time = 5'd5; prescale = 4'd0; start = 1'b1;
        wait_until(c + 3);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_count", count, 0);
        chk("mrst_ovf", ovf, 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mrst_no_restart", busy, 0);
        end
        start = 1'b0;
        @(negedge clk);
        start_pulse(3, 1, 1'b1);
        chk("restart_busy", busy, 1);
        repeat (11) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
